adc_frame_pack: RTL

- Downstream consumer of the channel-count configuration (adc_rx_len, adc_cnt).
- Drains ADC sample bytes from the ADC receive FIFO and emits one framed byte stream per start request toward the Ethernet TX path.
- Frame layout: 5-byte header, then adc_cnt × adc_rx_len payload bytes, then an optional XOR checksum byte.
- Runs on fifo_clk, the same domain as the FIFO read side.

---
 rtl/adc_frame_pack.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_frame_pack.sv
// adc_frame_pack: drains ADC sample bytes from the RX FIFO into one framed byte stream per start.
// Define ADC_FRAME_CHKSUM_EN to append an XOR checksum byte after the payload.
module adc_frame_pack #(
    parameter logic [7:0]  HEAD0   = 8'h55,
    parameter logic [7:0]  HEAD1   = 8'hAA,
    parameter logic [15:0] TIMEOUT = 16'd4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] adc_rx_len,
    input  logic [7:0] adc_cnt,
    input  logic [7:0] fifo_rxd,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic [7:0] txd,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HEAD = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
`ifdef ADC_FRAME_CHKSUM_EN
    localparam logic [2:0] CSUM = 3'd3;
`endif
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [9:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [17:0] payload_left_q, payload_left_d;
    logic [17:0] reads_left_q, reads_left_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_valid_q, tx_valid_d;
    logic        rd_pend_q, rd_pend_d;
    logic [7:0]  skid0_q, skid0_d, skid1_q, skid1_d;
    logic [1:0]  skid_cnt_q, skid_cnt_d;
    logic [15:0] timer_q, timer_d;
    logic        err_q, err_d;
`ifdef ADC_FRAME_CHKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif
    logic        xfer, out_free, pop, push, rd_en;
    logic [7:0]  hdr_next;
    logic [17:0] product;

    assign product = 18'(adc_cnt) * 18'(adc_rx_len);

    always_comb begin
        case (hdr_idx_q)
            3'd0:    hdr_next = HEAD1;
            3'd1:    hdr_next = cnt_q;
            3'd2:    hdr_next = {6'b0, len_q[9:8]};
            default: hdr_next = len_q[7:0];
        endcase
    end

    // A read is only issued if the skid buffer is guaranteed a slot when the byte returns.
    assign rd_en = (state_q == DATA) && !fifo_empty && (reads_left_q != 18'd0) &&
                   ((skid_cnt_q == 2'd0) || ((skid_cnt_q == 2'd1) && !rd_pend_q));

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        payload_left_d = payload_left_q;
        reads_left_d   = reads_left_q;
        hdr_idx_d      = hdr_idx_q;
        txd_d          = txd_q;
        tx_valid_d     = tx_valid_q;
        rd_pend_d      = 1'b0;
        skid0_d        = skid0_q;
        skid1_d        = skid1_q;
        skid_cnt_d     = skid_cnt_q;
        timer_d        = timer_q;
        err_d          = 1'b0;
`ifdef ADC_FRAME_CHKSUM_EN
        csum_d         = csum_q;
`endif
        xfer     = tx_valid_q && tx_ready;
        out_free = !tx_valid_q || tx_ready;
        pop      = 1'b0;
        push     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d          = adc_rx_len;
                    cnt_d          = adc_cnt;
                    payload_left_d = product;
                    reads_left_d   = product;
                    hdr_idx_d      = 3'd0;
                    txd_d          = HEAD0;
                    tx_valid_d     = 1'b1;
                    timer_d        = 16'd0;
                    skid_cnt_d     = 2'd0;
`ifdef ADC_FRAME_CHKSUM_EN
                    csum_d         = 8'h00;
`endif
                    state_d        = HEAD;
                end
            end
            HEAD: begin
                if (xfer) begin
                    if (hdr_idx_q == 3'd4) begin
                        tx_valid_d = 1'b0;
                        if (payload_left_q == 18'd0) begin
`ifdef ADC_FRAME_CHKSUM_EN
                            txd_d      = csum_q;
                            tx_valid_d = 1'b1;
                            state_d    = CSUM;
`else
                            state_d    = DONE;
`endif
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        txd_d     = hdr_next;
                        hdr_idx_d = hdr_idx_q + 3'd1;
                    end
                end
            end
            DATA: begin
                rd_pend_d = rd_en;
                if (rd_en) begin
                    reads_left_d = reads_left_q - 18'd1;
                end
                // Output register takes the oldest byte: skid head first, then the returning FIFO byte.
                pop  = out_free && (skid_cnt_q != 2'd0);
                push = rd_pend_q && !(out_free && (skid_cnt_q == 2'd0));
                if (out_free) begin
                    if (skid_cnt_q != 2'd0) begin
                        txd_d      = skid0_q;
                        tx_valid_d = 1'b1;
                    end else if (rd_pend_q) begin
                        txd_d      = fifo_rxd;
                        tx_valid_d = 1'b1;
                    end else begin
                        tx_valid_d = 1'b0;
                    end
                end
                if (pop && push) begin
                    if (skid_cnt_q == 2'd1) begin
                        skid0_d = fifo_rxd;
                    end else begin
                        skid0_d = skid1_q;
                        skid1_d = fifo_rxd;
                    end
                end else if (pop) begin
                    skid0_d    = skid1_q;
                    skid_cnt_d = skid_cnt_q - 2'd1;
                end else if (push) begin
                    if (skid_cnt_q == 2'd0) begin
                        skid0_d = fifo_rxd;
                    end else begin
                        skid1_d = fifo_rxd;
                    end
                    skid_cnt_d = skid_cnt_q + 2'd1;
                end
                if (xfer) begin
                    payload_left_d = payload_left_q - 18'd1;
`ifdef ADC_FRAME_CHKSUM_EN
                    csum_d = csum_q ^ txd_q;
`endif
                    if (payload_left_q == 18'd1) begin
`ifdef ADC_FRAME_CHKSUM_EN
                        txd_d      = csum_q ^ txd_q;
                        tx_valid_d = 1'b1;
                        state_d    = CSUM;
`else
                        tx_valid_d = 1'b0;
                        state_d    = DONE;
`endif
                    end
                end
                if (rd_en) begin
                    timer_d = 16'd0;
                end else if (fifo_empty && (reads_left_q != 18'd0) && !rd_pend_q) begin
                    if (timer_q == TIMEOUT - 16'd1) begin
                        timer_d    = 16'd0;
                        tx_valid_d = 1'b0;
                        skid_cnt_d = 2'd0;
                        err_d      = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end else begin
                    timer_d = 16'd0;
                end
            end
`ifdef ADC_FRAME_CHKSUM_EN
            CSUM: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    state_d    = DONE;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            len_q          <= 10'd0;
            cnt_q          <= 8'd0;
            payload_left_q <= 18'd0;
            reads_left_q   <= 18'd0;
            hdr_idx_q      <= 3'd0;
            txd_q          <= 8'h00;
            tx_valid_q     <= 1'b0;
            rd_pend_q      <= 1'b0;
            skid0_q        <= 8'h00;
            skid1_q        <= 8'h00;
            skid_cnt_q     <= 2'd0;
            timer_q        <= 16'd0;
            err_q          <= 1'b0;
`ifdef ADC_FRAME_CHKSUM_EN
            csum_q         <= 8'h00;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            payload_left_q <= payload_left_d;
            reads_left_q   <= reads_left_d;
            hdr_idx_q      <= hdr_idx_d;
            txd_q          <= txd_d;
            tx_valid_q     <= tx_valid_d;
            rd_pend_q      <= rd_pend_d;
            skid0_q        <= skid0_d;
            skid1_q        <= skid1_d;
            skid_cnt_q     <= skid_cnt_d;
            timer_q        <= timer_d;
            err_q          <= err_d;
`ifdef ADC_FRAME_CHKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign fifo_rd_en = rd_en;
    assign txd        = txd_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign done       = (state_q == DONE);
    assign err        = err_q;
endmodule
